// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data memory responder.
// IO window offsets, CTRL bit positions and timer states.
package mem_bus_pkg;

   localparam logic [3:0] IO_LED     = 4'h0;
   localparam logic [3:0] IO_COUNT   = 4'h4;
   localparam logic [3:0] IO_COMPARE = 4'h8;
   localparam logic [3:0] IO_CTRL    = 4'hC;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ    = 1;
   localparam int CTRL_RELOAD = 2;

   typedef enum logic {
      T_IDLE,
      T_RUN
   } timer_state_t;

   // Packs the CTRL register image; unused bits read 0.
   function automatic logic [31:0] ctrl_word(
      input logic en,
      input logic irq,
      input logic reload
   );
      logic [31:0] w;
      w = '0;
      w[CTRL_EN]     = en;
      w[CTRL_IRQ]    = irq;
      w[CTRL_RELOAD] = reload;
      return w;
   endfunction

endpackage

// File: rtl/mmio_timer.sv
// Compare timer: COUNT, COMPARE, CTRL registers and run/idle FSM.
// Ports: clk, rst (async high), wr_en/addr/wdata write port,
// rdata combinational register mux, irq level flag.
module mmio_timer
   import mem_bus_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   timer_state_t state;
   logic [31:0]  count;
   logic [31:0]  compare;
   logic         reload;
   logic         match;
   logic         ctrl_wr;
   logic         cmp_wr;

   assign match   = (state == T_RUN) && (count == compare);
   assign ctrl_wr = wr_en && (addr == IO_CTRL);
   assign cmp_wr  = wr_en && (addr == IO_COMPARE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= T_IDLE;
         count   <= '0;
         compare <= '0;
         reload  <= 1'b0;
         irq     <= 1'b0;
      end else begin
         if (state == T_RUN) begin
            if (match) begin
               irq <= 1'b1;
               // Match action uses the RELOAD value held before any
               // same-edge CTRL write.
               if (reload)
                  count <= '0;
               else
                  state <= T_IDLE;
            end else begin
               count <= count + 32'd1;
            end
         end
         if (cmp_wr)
            compare <= wdata;
         if (ctrl_wr) begin
            // A written EN overrides the one-shot stop on a match edge.
            state  <= wdata[CTRL_EN] ? T_RUN : T_IDLE;
            reload <= wdata[CTRL_RELOAD];
            // Set beats clear when a match lands on the W1C edge.
            if (wdata[CTRL_IRQ] && !match)
               irq <= 1'b0;
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         IO_COUNT:   rdata = count;
         IO_COMPARE: rdata = compare;
         IO_CTRL:    rdata = ctrl_word(state == T_RUN, irq, reload);
         default:    rdata = '0;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side bus responder: word RAM plus LED/timer IO window.
// Ports: Clock, Reset (async high), Address, Wr, DataIn in;
// DataOut (registered read), LedOut, TimerIrq, BusErr out.
module data_mem_responder
   import mem_bus_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] Address,
   input  logic        Wr,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
   output logic [31:0] LedOut,
   output logic        TimerIrq,
   output logic        BusErr
);

   localparam int AW = $clog2(DEPTH_WORDS);

   // 33-bit compares so the window top cannot wrap.
   localparam logic [32:0] RAM_END = 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [32:0] IO_LO   = {1'b0, IO_BASE};
   localparam logic [32:0] IO_HI   = IO_LO + 33'd16;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [32:0]   addr_ext;
   logic          ram_hit;
   logic          io_hit;
   logic          legal;
   logic          ram_we;
   logic          io_we;
   logic [3:0]    offset;
   logic [AW-1:0] word_idx;
   logic [31:0]   led;
   logic [31:0]   timer_rdata;
   logic          timer_irq;

   assign addr_ext = {1'b0, Address};
   assign ram_hit  = addr_ext < RAM_END;
   assign io_hit   = (addr_ext >= IO_LO) && (addr_ext < IO_HI);
   assign legal    = (Address[1:0] == 2'b00) && (ram_hit || io_hit);
   assign ram_we   = Wr && legal && ram_hit;
   assign io_we    = Wr && legal && io_hit;
   assign offset   = Address[3:0];
   assign word_idx = Address[AW+1:2];

   mmio_timer u_timer (
      .clk   (Clock),
      .rst   (Reset),
      .wr_en (io_we),
      .addr  (offset),
      .wdata (DataIn),
      .rdata (timer_rdata),
      .irq   (timer_irq)
   );

   // RAM contents are deliberately not reset.
   always_ff @(posedge Clock) begin
      if (ram_we)
         mem[word_idx] <= DataIn;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         DataOut <= '0;
         BusErr  <= 1'b0;
         led     <= '0;
      end else begin
         BusErr <= !legal;
         if (!legal)
            DataOut <= '0;
         else if (ram_hit)
            DataOut <= mem[word_idx];
         else if (offset == IO_LED)
            DataOut <= led;
         else
            DataOut <= timer_rdata;
         if (io_we && (offset == IO_LED))
            led <= DataIn;
      end
   end

   assign LedOut   = led;
   assign TimerIrq = timer_irq;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder.
// Table vectors plus timer/reset sequences, scoreboard-checked.
module tb_data_mem_responder;

   localparam logic [31:0] A_LED = 32'hFFFF_FF00;
   localparam logic [31:0] A_CNT = 32'hFFFF_FF04;
   localparam logic [31:0] A_CMP = 32'hFFFF_FF08;
   localparam logic [31:0] A_CTL = 32'hFFFF_FF0C;

   localparam logic [3:0] M_D = 4'b0001;
   localparam logic [3:0] M_E = 4'b0010;
   localparam logic [3:0] M_L = 4'b0100;
   localparam logic [3:0] M_I = 4'b1000;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] Address = '0;
   logic        Wr = 1'b0;
   logic [31:0] DataIn = '0;
   logic [31:0] DataOut;
   logic [31:0] LedOut;
   logic        TimerIrq;
   logic        BusErr;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] din;
      logic [3:0]  mask;
      logic [31:0] dout;
      logic        err;
      logic [31:0] led;
      logic        irq;
   } vec_t;

   vec_t sb[$];
   vec_t tbl[$];
   vec_t got;

   data_mem_responder dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Address  (Address),
      .Wr       (Wr),
      .DataIn   (DataIn),
      .DataOut  (DataOut),
      .LedOut   (LedOut),
      .TimerIrq (TimerIrq),
      .BusErr   (BusErr)
   );

   always #5 Clock = ~Clock;

   function automatic void check(string n, logic [31:0] act,
                                 logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endfunction

   function automatic vec_t mk(string n, logic [31:0] a, logic w,
                               logic [31:0] d, logic [3:0] m,
                               logic [31:0] ed, logic ee,
                               logic [31:0] el, logic ei);
      vec_t v;
      v.name = n;
      v.addr = a;
      v.wr   = w;
      v.din  = d;
      v.mask = m;
      v.dout = ed;
      v.err  = ee;
      v.led  = el;
      v.irq  = ei;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      @(negedge Clock);
      Address = v.addr;
      Wr      = v.wr;
      DataIn  = v.din;
      sb.push_back(v);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge Clock);
         Address = '0;
         Wr      = 1'b0;
         DataIn  = '0;
      end
   endtask

   always @(posedge Clock) begin
      #1;
      if (sb.size() != 0) begin
         got = sb.pop_front();
         if (got.mask[0]) check({got.name, ".dout"}, DataOut, got.dout);
         if (got.mask[1]) check({got.name, ".err"}, 32'(BusErr), 32'(got.err));
         if (got.mask[2]) check({got.name, ".led"}, LedOut, got.led);
         if (got.mask[3]) check({got.name, ".irq"}, 32'(TimerIrq), 32'(got.irq));
      end
   end

   initial begin
      tbl.push_back(mk("wr10", 32'h10, 1, 32'hDEADBEEF, M_E, 0, 0, 0, 0));
      tbl.push_back(mk("rd10", 32'h10, 0, 0, M_D|M_E, 32'hDEADBEEF, 0, 0, 0));
      tbl.push_back(mk("wr14", 32'h14, 1, 32'h12345678, M_E, 0, 0, 0, 0));
      tbl.push_back(mk("rd14", 32'h14, 0, 0, M_D, 32'h12345678, 0, 0, 0));
      tbl.push_back(mk("rf_same", 32'h10, 1, 32'hCAFEF00D, M_D|M_E, 32'hDEADBEEF, 0, 0, 0));
      tbl.push_back(mk("rf_next", 32'h10, 0, 0, M_D, 32'hCAFEF00D, 0, 0, 0));
      tbl.push_back(mk("mis_wr", 32'h13, 1, 32'h11111111, M_D|M_E, 0, 1, 0, 0));
      tbl.push_back(mk("mis_keep", 32'h10, 0, 0, M_D|M_E, 32'hCAFEF00D, 0, 0, 0));
      tbl.push_back(mk("unmap", 32'h0001_0000, 0, 0, M_D|M_E, 0, 1, 0, 0));
      tbl.push_back(mk("ram_end", 32'h400, 0, 0, M_D|M_E, 0, 1, 0, 0));
      tbl.push_back(mk("wr_last", 32'h3FC, 1, 32'hA5A5A5A5, M_E, 0, 0, 0, 0));
      tbl.push_back(mk("rd_last", 32'h3FC, 0, 0, M_D, 32'hA5A5A5A5, 0, 0, 0));
      tbl.push_back(mk("rd_w0", 32'h10, 0, 0, M_D, 32'hCAFEF00D, 0, 0, 0));
      tbl.push_back(mk("led_wr", A_LED, 1, 32'hF0, M_E|M_L, 0, 0, 32'hF0, 0));
      tbl.push_back(mk("led_rd", A_LED, 0, 0, M_D|M_L, 32'hF0, 0, 32'hF0, 0));
      tbl.push_back(mk("io_above", 32'hFFFF_FF10, 1, 1, M_D|M_E|M_L, 0, 1, 32'hF0, 0));
      tbl.push_back(mk("io_below", 32'hFFFF_FEFC, 1, 2, M_E|M_L, 0, 1, 32'hF0, 0));
      tbl.push_back(mk("io_mis", 32'hFFFF_FF01, 1, 3, M_D|M_E|M_L, 0, 1, 32'hF0, 0));
      tbl.push_back(mk("cnt_rd", A_CNT, 0, 0, M_D|M_E, 0, 0, 0, 0));
      tbl.push_back(mk("cnt_wr", A_CNT, 1, 32'h55, M_E, 0, 0, 0, 0));
      tbl.push_back(mk("cnt_ro", A_CNT, 0, 0, M_D, 0, 0, 0, 0));
      tbl.push_back(mk("cmp_wr", A_CMP, 1, 32'h77, M_E, 0, 0, 0, 0));
      tbl.push_back(mk("cmp_rd", A_CMP, 0, 0, M_D, 32'h77, 0, 0, 0));
      tbl.push_back(mk("ctl_rd", A_CTL, 0, 0, M_D|M_I, 0, 0, 0, 0));

      repeat (2) @(negedge Clock);
      check("rst.dout", DataOut, 0);
      check("rst.led", LedOut, 0);
      check("rst.err", 32'(BusErr), 0);
      check("rst.irq", 32'(TimerIrq), 0);
      Reset = 1'b0;

      foreach (tbl[i]) drive(tbl[i]);

      // one-shot timer
      drive(mk("os_cmp", A_CMP, 1, 5, 0, 0, 0, 0, 0));
      drive(mk("os_go", A_CTL, 1, 1, M_I, 0, 0, 0, 0));
      for (int i = 0; i < 6; i++)
         drive(mk($sformatf("os_cnt%0d", i), A_CNT, 0, 0, M_D|M_I,
                  32'(i), 0, 0, (i == 5)));
      drive(mk("os_ctl", A_CTL, 0, 0, M_D|M_I, 32'h2, 0, 0, 1));
      drive(mk("os_hold", A_CNT, 0, 0, M_D, 5, 0, 0, 0));
      drive(mk("os_clr", A_CTL, 1, 2, M_I, 0, 0, 0, 0));
      drive(mk("os_ctl2", A_CTL, 0, 0, M_D|M_I, 0, 0, 0, 0));

      // reset while running at COUNT = 7
      drive(mk("mr_cmp", A_CMP, 1, 32'h100, 0, 0, 0, 0, 0));
      drive(mk("mr_go", A_CTL, 1, 1, 0, 0, 0, 0, 0));
      drive(mk("mr_cnt5", A_CNT, 0, 0, M_D, 5, 0, 0, 0));
      drive(mk("mr_cnt6", A_CNT, 0, 0, M_D|M_L, 6, 0, 32'hF0, 0));
      @(posedge Clock);
      #3;
      Address = '0;
      Wr      = 1'b0;
      Reset   = 1'b1;
      #1;
      check("mr.dout", DataOut, 0);
      check("mr.led", LedOut, 0);
      check("mr.err", 32'(BusErr), 0);
      check("mr.irq", 32'(TimerIrq), 0);
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      drive(mk("mr_c0", A_CNT, 0, 0, M_D|M_I, 0, 0, 0, 0));
      drive(mk("mr_idle", A_CNT, 0, 0, M_D, 0, 0, 0, 0));
      drive(mk("mr_ctl", A_CTL, 0, 0, M_D, 0, 0, 0, 0));
      drive(mk("mr_cmp0", A_CMP, 0, 0, M_D, 0, 0, 0, 0));
      drive(mk("mr_ram", 32'h10, 0, 0, M_D, 32'hCAFEF00D, 0, 0, 0));
      drive(mk("mr_ram2", 32'h3FC, 0, 0, M_D, 32'hA5A5A5A5, 0, 0, 0));

      // reload timer
      drive(mk("rl_cmp", A_CMP, 1, 3, 0, 0, 0, 0, 0));
      drive(mk("rl_go", A_CTL, 1, 5, M_I, 0, 0, 0, 0));
      for (int i = 0; i < 7; i++)
         drive(mk($sformatf("rl_cnt%0d", i), A_CNT, 0, 0, M_D|M_I,
                  32'(i % 4), 0, 0, (i >= 3)));
      drive(mk("rl_w1c", A_CTL, 1, 7, M_I, 0, 0, 0, 1));
      drive(mk("rl_wrap", A_CNT, 0, 0, M_D|M_I, 0, 0, 0, 1));
      drive(mk("rl_ctl", A_CTL, 0, 0, M_D, 7, 0, 0, 0));
      drive(mk("rl_stop", A_CTL, 1, 2, M_I, 0, 0, 0, 0));
      drive(mk("rl_ctl2", A_CTL, 0, 0, M_D, 0, 0, 0, 0));

      idle(3);
      if (sb.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
